// File: rtl/hazard_pkg.sv
// Purpose: shared types and stall-count constants for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: hazard_state_t FSM encoding, stall-count constants, max helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        MEM_WAIT  = 2'd2
    } hazard_state_t;

    // Bubble counts on top of the EX/MEM and MEM/WB bypass paths.
    localparam logic [1:0] LOAD_USE_STALLS    = 2'd1;
    localparam logic [1:0] BRANCH_LOAD_STALLS = 2'd2;
    localparam logic [1:0] BRANCH_ALU_STALLS  = 2'd1;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Purpose: compare a producer rd against the ID instruction's rs1/rs2.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rd, rs1, rs2 (5b register indices), uses_rs1/uses_rs2 (operand actually read),
//        match (rd is non-zero and equals a source register that is actually read).
module hazard_match (
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    output logic       match
);

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign match = (rd != 5'd0) &&
                   ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush/freeze sequencing for the 5-stage pipeline beside decode.
// Latency: outputs combinational from state + inputs; state and stall counter registered.
// Backpressure: mem_busy freezes the whole pipe and holds the FSM until it drops.
// Ports: clk, rst (sync, active-high); ID operand info, ID/EX and EX/MEM producer info,
//        mem_busy in; pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, stall_busy out.
// Option: HAZARD_PERF_CNT_EN adds 32-bit stall_cycles, flush_count, freeze_cycles outputs.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_is_branch,
    input  logic        branch_taken,
    input  logic [4:0]  idex_rd,
    input  logic        idex_regwrite,
    input  logic        idex_memread,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_memread,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic        stall_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] freeze_cycles
`endif
);

    hazard_state_t state_q, state_d;
    hazard_state_t saved_q, saved_d;
    hazard_state_t eff_state;
    logic [1:0]    stall_cnt_q, stall_cnt_d;
    logic [1:0]    need_n;
    logic          match_idex;
    logic          match_exmem;

    hazard_match u_match_idex (
        .rd       (idex_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .match    (match_idex)
    );

    hazard_match u_match_exmem (
        .rd       (exmem_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .match    (match_exmem)
    );

    // Branches compare in ID, so they need operands one stage earlier than ALU
    // ops: an ALU result still in EX, or a load anywhere in EX/MEM, is too late.
    always_comb begin
        need_n = 2'd0;
        if (id_is_branch) begin
            if (idex_regwrite && !idex_memread && match_idex)
                need_n = max2(need_n, BRANCH_ALU_STALLS);
            if (idex_memread && match_idex)
                need_n = max2(need_n, BRANCH_LOAD_STALLS);
            if (exmem_memread && match_exmem)
                need_n = max2(need_n, LOAD_USE_STALLS);
        end else if (idex_memread && match_idex) begin
            need_n = LOAD_USE_STALLS;
        end
    end

    // After a freeze the FSM resumes exactly where it was, with no dead cycle:
    // once mem_busy drops the saved state is acted on immediately.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        stall_cnt_d = stall_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        stall_busy  = (eff_state == HAZ_STALL);

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            stall_busy  = 1'b0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            saved_d     = eff_state;
            state_d     = MEM_WAIT;
        end else begin
            case (eff_state)
                HAZ_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    state_d     = (stall_cnt_q <= 2'd1) ? RUN : HAZ_STALL;
                end
                default: begin
                    state_d = RUN;
                    if (need_n != 2'd0) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        // The current cycle is the first bubble; count the rest.
                        if (need_n > 2'd1) begin
                            state_d     = HAZ_STALL;
                            stall_cnt_d = need_n - 2'd1;
                        end
                    end else begin
                        ifid_flush = id_is_branch && branch_taken;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            stall_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= 32'd0;
            flush_count   <= 32'd0;
            freeze_cycles <= 32'd0;
        end else begin
            stall_cycles  <= stall_cycles  + {31'd0, idex_bubble};
            flush_count   <= flush_count   + {31'd0, ifid_flush};
            freeze_cycles <= freeze_cycles + {31'd0, pipe_freeze};
        end
    end
`endif

endmodule
